// File: rtl/mem.sv
// Beta pipeline memory-access stage: registers the ALU-stage instruction and runs the data-memory
// handshake. Define MEM_ALIGN_CHECK_EN to trap misaligned LD/ST instead of aligning them down.
module mem (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic        op_ld_or_ldr,
    input  logic        op_st,
    input  logic        rf_w_mux_jump,
    input  logic [31:0] pc,
    input  logic [31:0] ir,
    input  logic [31:0] y,
    input  logic [31:0] st_data,
    output logic        stall_out,
    output logic        op_ld_or_ldr_next,
    output logic        op_st_next,
    output logic        rf_w_mux_jump_next,
    output logic [31:0] pc_next,
    output logic [31:0] ir_next,
    output logic [31:0] y_next,
    output logic [31:0] mem_rd,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        mem_misalign
);

    logic        valid_q, valid_d;
    logic        ld_q, ld_d;
    logic        st_q, st_d;
    logic        jmp_q, jmp_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] y_q, y_d;
    logic [31:0] sd_q, sd_d;
    logic        done_q, done_d;
    logic [31:0] mem_rd_q, mem_rd_d;

    logic access;
    logic misalign;
    logic access_req;
    logic bubble;

    always_comb begin
        access = valid_q & (ld_q | st_q) & ~done_q;
`ifdef MEM_ALIGN_CHECK_EN
        misalign = access & (y_q[1:0] != 2'b00);
`else
        misalign = 1'b0;
`endif
        access_req = access & ~misalign;
        stall_out  = access_req & ~dmem_ready;
        // A trapped misaligned access is squashed so wb never writes the register file.
        bubble     = ~valid_q | stall_out | misalign;
    end

    always_comb begin
        dmem_req     = access_req;
        dmem_we      = st_q;
        dmem_addr    = {y_q[31:2], 2'b00};
        dmem_wdata   = sd_q;
        mem_misalign = misalign;
        mem_rd       = mem_rd_q;
        if (bubble) begin
            op_ld_or_ldr_next  = 1'b0;
            op_st_next         = 1'b1;
            rf_w_mux_jump_next = 1'b0;
            pc_next            = 32'd0;
            ir_next            = 32'd0;
            y_next             = 32'd0;
        end else begin
            op_ld_or_ldr_next  = ld_q;
            op_st_next         = st_q;
            rf_w_mux_jump_next = jmp_q;
            pc_next            = pc_q;
            ir_next            = ir_q;
            y_next             = y_q;
        end
    end

    always_comb begin
        valid_d  = valid_q;
        ld_d     = ld_q;
        st_d     = st_q;
        jmp_d    = jmp_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        y_d      = y_q;
        sd_d     = sd_q;
        done_d   = done_q;
        mem_rd_d = mem_rd_q;
        if (access_req && dmem_ready) begin
            done_d = 1'b1;
        end
        if (access_req && !st_q && dmem_ready) begin
            mem_rd_d = dmem_rdata;
        end
        // A load at the completing edge overrides done: the new instruction's state applies.
        if (!stall_out) begin
            valid_d = valid_in;
            ld_d    = op_ld_or_ldr;
            st_d    = op_st;
            jmp_d   = rf_w_mux_jump;
            pc_d    = pc;
            ir_d    = ir;
            y_d     = y;
            sd_d    = st_data;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            ld_q     <= 1'b0;
            st_q     <= 1'b0;
            jmp_q    <= 1'b0;
            pc_q     <= 32'd0;
            ir_q     <= 32'd0;
            y_q      <= 32'd0;
            sd_q     <= 32'd0;
            done_q   <= 1'b0;
            mem_rd_q <= 32'd0;
        end else begin
            valid_q  <= valid_d;
            ld_q     <= ld_d;
            st_q     <= st_d;
            jmp_q    <= jmp_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            y_q      <= y_d;
            sd_q     <= sd_d;
            done_q   <= done_d;
            mem_rd_q <= mem_rd_d;
        end
    end

endmodule

// File: tb/tb_mem.sv
// Scoreboard bench for mem: expected wb hand-offs, memory requests and load data are queued at
// issue time and compared as the stage produces them. Honours MEM_ALIGN_CHECK_EN.
module tb_mem;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in, op_ld_or_ldr, op_st, rf_w_mux_jump;
    logic [31:0] pc, ir, y, st_data;
    logic        stall_out, op_ld_or_ldr_next, op_st_next, rf_w_mux_jump_next;
    logic [31:0] pc_next, ir_next, y_next, mem_rd;
    logic        dmem_req, dmem_we, dmem_ready, mem_misalign;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;

    mem u_dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .valid_in           (valid_in),
        .op_ld_or_ldr       (op_ld_or_ldr),
        .op_st              (op_st),
        .rf_w_mux_jump      (rf_w_mux_jump),
        .pc                 (pc),
        .ir                 (ir),
        .y                  (y),
        .st_data            (st_data),
        .stall_out          (stall_out),
        .op_ld_or_ldr_next  (op_ld_or_ldr_next),
        .op_st_next         (op_st_next),
        .rf_w_mux_jump_next (rf_w_mux_jump_next),
        .pc_next            (pc_next),
        .ir_next            (ir_next),
        .y_next             (y_next),
        .mem_rd             (mem_rd),
        .dmem_req           (dmem_req),
        .dmem_we            (dmem_we),
        .dmem_addr          (dmem_addr),
        .dmem_wdata         (dmem_wdata),
        .dmem_ready         (dmem_ready),
        .dmem_rdata         (dmem_rdata),
        .mem_misalign       (mem_misalign)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        ld;
        logic        st;
        logic        jmp;
        logic [31:0] pc;
        logic [31:0] ir;
        logic [31:0] y;
        logic [31:0] rdata;
    } wb_t;

    typedef struct packed {
        int unsigned waits;
        logic [31:0] rdata;
    } resp_t;

    localparam logic [98:0] Bubble = {1'b0, 1'b1, 1'b0, 96'd0};

    wb_t         wb_q[$];
    logic [64:0] req_q[$];
    resp_t       resp_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int stall_cnt = 0;
    int req_cycles = 0;
    int mis_cnt = 0;
    logic        accepted;
    logic        rd_pend = 1'b0;
    logic [31:0] rd_exp;
    logic        busy = 1'b0;
    int unsigned cnt = 0;
    resp_t       cur;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory model: serves queued responses, inserting the requested number of wait cycles.
    task automatic mem_respond();
        if (dmem_req) begin
            if (!busy && resp_q.size() > 0) begin
                cur  = resp_q.pop_front();
                cnt  = cur.waits;
                busy = 1'b1;
            end
            if (cnt == 0) begin
                dmem_ready = 1'b1;
                dmem_rdata = cur.rdata;
                busy       = 1'b0;
            end else begin
                dmem_ready = 1'b0;
                dmem_rdata = $urandom;
                cnt--;
            end
        end else begin
            dmem_ready = 1'b0;
            dmem_rdata = $urandom;
            busy       = 1'b0;
        end
    endtask

    task automatic tick();
        logic [98:0] outf;
        wb_t         e;
        logic [64:0] r;
        @(negedge clk);
        outf = {op_ld_or_ldr_next, op_st_next, rf_w_mux_jump_next, pc_next, ir_next, y_next};
        if (rd_pend) begin
            check_eq("mem_rd", mem_rd, rd_exp);
            rd_pend = 1'b0;
        end
        if (dmem_req) req_cycles++;
        if (mem_misalign) mis_cnt++;
        if (dmem_req && dmem_ready) begin
            check_eq("req_expected", req_q.size() > 0, 1);
            if (req_q.size() > 0) begin
                r = req_q.pop_front();
                check_eq("dmem_we_addr_wdata", {dmem_we, dmem_addr, dmem_wdata}, r);
            end
        end
        if (stall_out) begin
            stall_cnt++;
            check_eq("stall_bubble", outf, Bubble);
        end
        if (outf != Bubble) begin
            check_eq("wb_expected", wb_q.size() > 0, 1);
            if (wb_q.size() > 0) begin
                e = wb_q.pop_front();
                check_eq("wb_fields", outf, {e.ld, e.st, e.jmp, e.pc, e.ir, e.y});
                if (e.ld) begin
                    rd_pend = 1'b1;
                    rd_exp  = e.rdata;
                end
            end
        end
        accepted = !stall_out;
        @(posedge clk);
        #1;
        mem_respond();
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic issue(input logic ld, input logic st, input logic jmp, input logic [31:0] pc_v,
                         input logic [31:0] ir_v, input logic [31:0] y_v, input logic [31:0] sd_v,
                         input int unsigned waits, input logic [31:0] rd_v);
        logic mis;
        int   n;
        valid_in      = 1'b1;
        op_ld_or_ldr  = ld;
        op_st         = st;
        rf_w_mux_jump = jmp;
        pc            = pc_v;
        ir            = ir_v;
        y             = y_v;
        st_data       = sd_v;
`ifdef MEM_ALIGN_CHECK_EN
        mis = (ld | st) && (y_v[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        if (!mis) wb_q.push_back('{ld, st, jmp, pc_v, ir_v, y_v, rd_v});
        if ((ld | st) && !mis) begin
            req_q.push_back({st, y_v[31:2], 2'b00, sd_v});
            resp_q.push_back('{waits, rd_v});
        end
        n = 0;
        do begin
            tick();
            n++;
        end while (!accepted && n < 50);
        check_eq("issue_accepted", accepted, 1);
        valid_in = 1'b0;
    endtask

    int s0, r0, m0;

    initial begin
        rst_n = 1'b0;
        valid_in = 1'b0; op_ld_or_ldr = 1'b0; op_st = 1'b0; rf_w_mux_jump = 1'b0;
        pc = '0; ir = '0; y = '0; st_data = '0;
        dmem_ready = 1'b0; dmem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_dmem_req", dmem_req, 0);
        check_eq("rst_stall", stall_out, 0);
        check_eq("rst_op_st_next", op_st_next, 1);
        check_eq("rst_mem_rd", mem_rd, 0);
        @(posedge clk);
        #1;
        mem_respond();

        // Non-memory op.
        r0 = req_cycles;
        issue(1'b0, 1'b0, 1'b0, 32'h100, 32'h8000_0001, 32'h1234, 32'h0, 0, 32'h0);
        idle(2);
        check_eq("add_no_req", req_cycles - r0, 0);

        // Load with two wait cycles.
        s0 = stall_cnt;
        issue(1'b1, 1'b0, 1'b0, 32'h104, 32'h6000_0040, 32'h40, 32'h0, 2, 32'hDEAD_BEEF);
        idle(4);
        check_eq("ld_wait_stalls", stall_cnt - s0, 2);

        // Zero-wait store.
        s0 = stall_cnt; r0 = req_cycles;
        issue(1'b0, 1'b1, 1'b0, 32'h108, 32'h6400_0080, 32'h80, 32'hA5A5_A5A5, 0, 32'h0);
        idle(2);
        check_eq("st_req_cycles", req_cycles - r0, 1);
        check_eq("st_no_stall", stall_cnt - s0, 0);

        // Three back-to-back zero-wait loads.
        s0 = stall_cnt; r0 = req_cycles;
        issue(1'b1, 1'b0, 1'b0, 32'h10C, 32'h1, 32'h10, 32'h0, 0, 32'h1111_1111);
        issue(1'b1, 1'b0, 1'b0, 32'h110, 32'h2, 32'h14, 32'h0, 0, 32'h2222_2222);
        issue(1'b1, 1'b0, 1'b0, 32'h114, 32'h3, 32'h18, 32'h0, 0, 32'h3333_3333);
        idle(3);
        check_eq("b2b_req_cycles", req_cycles - r0, 3);
        check_eq("b2b_no_stall", stall_cnt - s0, 0);

        // Random mix of ops and wait states.
        for (int i = 0; i < 10; i++) begin
            int unsigned op;
            op = $urandom_range(0, 2);
            issue(op == 1, op == 2, (op == 0) && $urandom_range(0, 1) == 1,
                  $urandom | 32'h4, $urandom, $urandom & 32'hFFFF_FFFC, $urandom,
                  $urandom_range(0, 3), $urandom);
        end
        idle(5);

        // Misaligned load.
        r0 = req_cycles; m0 = mis_cnt;
        issue(1'b1, 1'b0, 1'b0, 32'h200, 32'h6000_0042, 32'h42, 32'h0, 0, 32'h5555_AAAA);
        idle(3);
`ifdef MEM_ALIGN_CHECK_EN
        check_eq("misalign_pulse", mis_cnt - m0, 1);
        check_eq("misalign_no_req", req_cycles - r0, 0);
`else
        check_eq("misalign_flag_tied", mis_cnt - m0, 0);
        check_eq("misalign_aligned_req", req_cycles - r0, 1);
`endif

        // Reset in the middle of a three-wait load.
        issue(1'b1, 1'b0, 1'b0, 32'h300, 32'h6000_0100, 32'h100, 32'h0, 3, 32'h1234_5678);
        check_eq("mid_ld_req", dmem_req, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_dmem_req", dmem_req, 0);
        check_eq("arst_stall", stall_out, 0);
        check_eq("arst_misalign", mem_misalign, 0);
        check_eq("arst_op_st_next", op_st_next, 1);
        check_eq("arst_mem_rd", mem_rd, 0);
        wb_q.delete();
        req_q.delete();
        resp_q.delete();
        busy = 1'b0;
        cnt = 0;
        rd_pend = 1'b0;
        dmem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mem_respond();
        issue(1'b0, 1'b0, 1'b1, 32'h400, 32'h7, 32'h99, 32'h0, 0, 32'h0);
        idle(2);

        check_eq("wb_q_drained", wb_q.size(), 0);
        check_eq("req_q_drained", req_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
